// File: rtl/oled_spi_rx.sv
// oled_spi_rx: receive-side model of the OLED panel's serial input.
// Oversamples SCLK/MOSI/DC on the system clock, rebuilds bytes MSB-first and
// emits each completed byte as a one-cycle strobe tagged command or data.
// Optional byte counters are built only when OLED_SPI_RX_COUNT_EN is defined;
// otherwise cmd_count and data_count are tied to zero.
module oled_spi_rx #(
  parameter int IDLE_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             oled_spi_clk,
  input  logic             oled_spi_data,
  input  logic             oled_dc_n,
  input  logic             oled_reset_n,
  output logic [7:0]       rx_data,
  output logic             rx_is_data,
  output logic             rx_valid,
  output logic             rx_error,
  output logic [CNT_W-1:0] cmd_count,
  output logic [CNT_W-1:0] data_count
);

  typedef enum logic [1:0] {
    HELD  = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam int              TW      = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TW-1:0]   TO_LAST = TW'(IDLE_TIMEOUT - 1);

  logic [2:0]    sclk_s;   // [0],[1] synchronizer, [2] edge-detect history
  logic [1:0]    data_s;
  logic [1:0]    dc_s;
  logic [1:0]    rstn_s;
  logic          rise_q;   // registered SCLK rising edge
  logic          bit_q;    // MOSI aligned with rise_q
  logic          dc_q;     // DC aligned with rise_q
  logic          rstn_ok;
  logic          byte_done;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] to_cnt;

  // Synchronize all panel pins and register the SCLK rising edge with its data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: SCLK history resets to the idle-high level so that leaving reset
      // with the line high never looks like a rising edge.
      sclk_s <= 3'b111;
      data_s <= 2'b00;
      dc_s   <= 2'b00;
      rstn_s <= 2'b00;
      rise_q <= 1'b0;
      bit_q  <= 1'b0;
      dc_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each flop take the previous value
      // of its neighbour, which is what turns this chain into a shift register.
      sclk_s <= {sclk_s[1:0], oled_spi_clk};
      data_s <= {data_s[0], oled_spi_data};
      dc_s   <= {dc_s[0], oled_dc_n};
      rstn_s <= {rstn_s[0], oled_reset_n};
      rise_q <= sclk_s[1] & ~sclk_s[2];
      bit_q  <= data_s[1];
      dc_q   <= dc_s[1];
    end
  end

  assign rstn_ok   = rstn_s[1];
  // A panel reset in the same cycle as the 8th edge suppresses the byte.
  assign byte_done = (state == SHIFT) && rstn_ok && rise_q && (bit_cnt == 3'd7);

  // Receive FSM: bit assembly, idle timeout and registered byte/error strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= HELD;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      to_cnt     <= '0;
      rx_data    <= 8'h00;
      rx_is_data <= 1'b0;
      rx_valid   <= 1'b0;
      rx_error   <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle so they can only be one cycle wide.
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      case (state)
        HELD: begin
          bit_cnt <= 3'd0;
          shreg   <= 8'h00;
          to_cnt  <= '0;
          if (rstn_ok) state <= IDLE;
        end
        IDLE: begin
          bit_cnt <= 3'd0;
          to_cnt  <= '0;
          if (!rstn_ok) begin
            state <= HELD;
          end else if (rise_q) begin
            shreg   <= {shreg[6:0], bit_q};
            bit_cnt <= 3'd1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!rstn_ok) begin
            rx_error <= 1'b1;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            to_cnt   <= '0;
            state    <= HELD;
          end else if (byte_done) begin
            rx_data    <= {shreg[6:0], bit_q};
            rx_is_data <= dc_q;
            rx_valid   <= 1'b1;
            bit_cnt    <= 3'd0;
            to_cnt     <= '0;
            state      <= IDLE;
          end else if (rise_q) begin
            // An edge always beats a coincident timeout.
            shreg   <= {shreg[6:0], bit_q};
            bit_cnt <= bit_cnt + 3'd1;
            to_cnt  <= '0;
          end else if (to_cnt == TO_LAST) begin
            rx_error <= 1'b1;
            bit_cnt  <= 3'd0;
            to_cnt   <= '0;
            state    <= IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: state <= HELD;
      endcase
    end
  end

`ifdef OLED_SPI_RX_COUNT_EN
  // Saturating byte counters; only the system reset clears them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_count  <= '0;
      data_count <= '0;
    end else if (byte_done) begin
      if (dc_q) begin
        if (data_count != '1) data_count <= data_count + CNT_W'(1);
      end else begin
        if (cmd_count != '1) cmd_count <= cmd_count + CNT_W'(1);
      end
    end
  end
`else
  assign cmd_count  = '0;
  assign data_count = '0;
`endif

endmodule

// File: tb/tb_oled_spi_rx.sv
// Self-checking bench for oled_spi_rx: table vectors, hand-written corner
// sequences and randomized bytes against a byte-stream reference model.
module tb_oled_spi_rx;

  localparam int CNT_W = 6;
  localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef OLED_SPI_RX_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             oled_spi_clk;
  logic             oled_spi_data;
  logic             oled_dc_n;
  logic             oled_reset_n;
  logic [7:0]       rx_data;
  logic             rx_is_data;
  logic             rx_valid;
  logic             rx_error;
  logic [CNT_W-1:0] cmd_count;
  logic [CNT_W-1:0] data_count;

  oled_spi_rx #(.IDLE_TIMEOUT(64), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .oled_spi_clk (oled_spi_clk),
    .oled_spi_data(oled_spi_data),
    .oled_dc_n    (oled_dc_n),
    .oled_reset_n (oled_reset_n),
    .rx_data      (rx_data),
    .rx_is_data   (rx_is_data),
    .rx_valid     (rx_valid),
    .rx_error     (rx_error),
    .cmd_count    (cmd_count),
    .data_count   (data_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic       dc;
    int         nbits;
    int         exp_valid;
    int         exp_err;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: expected byte stream, error count, byte counts.
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int m_err  = 0;
  int m_cmd  = 0;
  int m_data = 0;

  // Monitor state.
  int n_err      = 0;
  bit prev_valid = 1'b0;
  bit prev_err   = 1'b0;
  bit overlap    = 1'b0;
  bit wide       = 1'b0;

  // Observe strobes away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (rx_valid) got_q.push_back({rx_is_data, rx_data});
      if (rx_error) n_err <= n_err + 1;
      if (rx_valid && rx_error) overlap <= 1'b1;
      if ((rx_valid && prev_valid) || (rx_error && prev_err)) wide <= 1'b1;
      prev_valid <= rx_valid;
      prev_err   <= rx_error;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input logic dc_v, input int nbits, input int ph);
    for (int i = 0; i < nbits; i++) begin
      oled_spi_clk  = 1'b0;
      oled_spi_data = b[7-i];
      oled_dc_n     = dc_v;
      tick(ph);
      oled_spi_clk  = 1'b1;
      tick(ph);
    end
  endtask

  // Model a fully delivered byte.
  task automatic model_byte(input logic [7:0] b, input logic dc_v);
    exp_q.push_back({dc_v, b});
    if (dc_v) m_data = (m_data == MAXC) ? MAXC : m_data + 1;
    else      m_cmd  = (m_cmd  == MAXC) ? MAXC : m_cmd  + 1;
  endtask

  task automatic verify(input string tag);
    logic [8:0] g;
    logic [8:0] e;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_byte"}, g, e);
    end
    got_q.delete();
    exp_q.delete();
    check({tag, "_errors"}, n_err, m_err);
    check({tag, "_cmd_count"}, cmd_count, COUNT_EN ? m_cmd : 0);
    check({tag, "_data_count"}, data_count, COUNT_EN ? m_data : 0);
  endtask

  vec_t tbl [7];
  string msg;

  initial begin
    msg = "ThanksAnithaMam";
    tbl[0] = '{8'hAF, 1'b0, 8, 1, 0};
    tbl[1] = '{8'hA5, 1'b1, 5, 0, 1};
    tbl[2] = '{8'h3C, 1'b1, 8, 1, 0};
    tbl[3] = '{8'h12, 1'b0, 1, 0, 1};
    tbl[4] = '{8'hFF, 1'b1, 8, 1, 0};
    tbl[5] = '{8'h00, 1'b0, 8, 1, 0};
    tbl[6] = '{8'hC3, 1'b0, 7, 0, 1};

    reset         = 1'b1;
    oled_spi_clk  = 1'b1;
    oled_spi_data = 1'b0;
    oled_dc_n     = 1'b0;
    oled_reset_n  = 1'b1;
    tick(3);
    check("reset_rx_data",    rx_data,    8'h00);
    check("reset_rx_is_data", rx_is_data, 1'b0);
    check("reset_rx_valid",   rx_valid,   1'b0);
    check("reset_rx_error",   rx_error,   1'b0);
    check("reset_cmd_count",  cmd_count,  0);
    check("reset_data_count", data_count, 0);
    reset = 1'b0;
    tick(5);

    // Table vectors: full bytes and partial bytes that must time out.
    for (int i = 0; i < 7; i++) begin
      int v0;
      int e0;
      v0 = got_q.size();
      e0 = n_err;
      send_bits(tbl[i].data, tbl[i].dc, tbl[i].nbits, 5);
      tick(tbl[i].nbits < 8 ? 100 : 10);
      check("tbl_valid_seen", got_q.size() - v0, tbl[i].exp_valid);
      check("tbl_error_seen", n_err - e0, tbl[i].exp_err);
      if (tbl[i].exp_valid != 0) model_byte(tbl[i].data, tbl[i].dc);
      m_err += tbl[i].exp_err;
      verify("tbl");
    end

    // Back-to-back text bytes.
    for (int i = 0; i < msg.len(); i++) begin
      send_bits(msg[i], 1'b1, 8, 5);
      model_byte(msg[i], 1'b1);
    end
    tick(10);
    check("text_first_T", got_q.size() > 0 ? got_q[0] : 9'h000, {1'b1, 8'h54});
    check("text_last_m", got_q.size() > 0 ? got_q[got_q.size()-1] : 9'h000, {1'b1, 8'h6D});
    verify("text");

    // Panel reset mid-byte: error, then edges ignored while held.
    send_bits(8'hE7, 1'b0, 3, 5);
    oled_reset_n = 1'b0;
    tick(10);
    m_err++;
    send_bits(8'h5A, 1'b0, 8, 5);
    tick(10);
    verify("held");
    oled_reset_n = 1'b1;
    tick(5);
    send_bits(8'h8D, 1'b0, 8, 5);
    tick(10);
    model_byte(8'h8D, 1'b0);
    verify("held_release");

    // Panel reset coincident with the 8th edge: reset wins.
    send_bits(8'h55, 1'b1, 7, 5);
    oled_spi_clk  = 1'b0;
    oled_spi_data = 1'b1;
    tick(5);
    oled_spi_clk = 1'b1;
    oled_reset_n = 1'b0;
    tick(10);
    m_err++;
    verify("reset_vs_edge");
    oled_reset_n = 1'b1;
    tick(5);

    // Randomized traffic, including random partial bytes and phase widths.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      logic       d;
      int         nb;
      int         ph;
      b  = 8'($urandom);
      d  = 1'($urandom);
      nb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 8;
      ph = $urandom_range(3, 6);
      send_bits(b, d, nb, ph);
      if (nb == 8) begin
        model_byte(b, d);
        tick(8);
      end else begin
        m_err++;
        tick(100);
      end
      if (i % 10 == 9) verify("rand");
    end

    // Asynchronous system reset mid-byte.
    send_bits(8'h7E, 1'b1, 8, 5);
    tick(10);
    model_byte(8'h7E, 1'b1);
    verify("pre_async");
    send_bits(8'hB4, 1'b1, 4, 5);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_rx_data",    rx_data,    8'h00);
    check("async_rx_is_data", rx_is_data, 1'b0);
    check("async_rx_valid",   rx_valid,   1'b0);
    check("async_rx_error",   rx_error,   1'b0);
    check("async_cmd_count",  cmd_count,  0);
    check("async_data_count", data_count, 0);
    tick(3);
    reset = 1'b0;
    m_cmd  = 0;
    m_data = 0;
    got_q.delete();
    tick(5);
    send_bits(8'h01, 1'b0, 8, 5);
    tick(10);
    model_byte(8'h01, 1'b0);
    verify("post_async");

    // Drive the command counter up to one below saturation, then past it.
    while (m_cmd < MAXC - 1) begin
      logic [7:0] b;
      b = 8'($urandom);
      send_bits(b, 1'b0, 8, 5);
      model_byte(b, 1'b0);
    end
    tick(10);
    verify("sat_pre");
    for (int i = 0; i < 3; i++) begin
      send_bits(8'hA0 + 8'(i), 1'b0, 8, 5);
      model_byte(8'hA0 + 8'(i), 1'b0);
    end
    tick(10);
    verify("sat_post");
    check("sat_cmd_all_ones", cmd_count, COUNT_EN ? MAXC : 0);

    check("valid_error_exclusive", overlap, 1'b0);
    check("strobe_one_cycle", wide, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
